// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and FSM state encoding for the two-port cache-to-memory arbiter.
`ifndef Width_of_A_Low
`define Width_of_A_Low 28
`endif
`ifndef Memory_Block_Size
`define Memory_Block_Size 128
`endif

package mem_port_arbiter_pkg;

  localparam int ARB_N_PORTS = 2;
  localparam int ARB_A_W     = `Width_of_A_Low;
  localparam int ARB_B_W     = `Memory_Block_Size;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between the I-cache (port 0) and D-cache (port 1) requesters.
// ARB_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise port 1 wins ties.
module arb_pick (
  input  logic Req_P0,
  input  logic Req_P1,
  input  logic last_grant,
  output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
  logic tie_winner_s;
  assign tie_winner_s = ~last_grant;
`else
  logic tie_winner_s;
  logic unused_last_grant_s;
  assign tie_winner_s        = 1'b1;
  assign unused_last_grant_s = last_grant;
`endif

  // Single requester wins outright; a tie is settled by the build-selected policy
  always_comb begin
    winner = 1'b0;
    if (Req_P0 && Req_P1) begin
      winner = tie_winner_s;
    end else if (Req_P1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port block arbiter in front of a single memory port, with lock for write-back/refill pairs.
// Build option: ARB_ROUND_ROBIN_EN (round-robin ties instead of fixed D-cache priority).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_PORTS = ARB_N_PORTS,
  parameter int A_W = ARB_A_W,
  parameter int B_W = ARB_B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Req_P0,
  input  logic           Req_P1,
  input  logic           Wr_P0,
  input  logic           Wr_P1,
  input  logic           Lock_P0,
  input  logic           Lock_P1,
  input  logic [A_W-1:0] A_P0,
  input  logic [A_W-1:0] A_P1,
  input  logic [B_W-1:0] DO_P0,
  input  logic [B_W-1:0] DO_P1,
  output logic           Rdy_P0,
  output logic           Rdy_P1,
  output logic [B_W-1:0] DI_P0,
  output logic [B_W-1:0] DI_P1,
  output logic           Req_Low,
  output logic           Wr_Low,
  output logic [A_W-1:0] A_Low,
  output logic [B_W-1:0] DO_Low,
  input  logic           Rdy_Low,
  input  logic [B_W-1:0] DI_Low,
  output logic           Grant
);

  localparam int PTR_W = $clog2(N_PORTS);

  arb_state_e     state_r;
  logic [PTR_W-1:0] last_r;
  logic           lock_r;
  logic           winner_s;
  logic           src_s;
  logic           req_s;
  logic           lock_s;
  logic           wr_s;
  logic [A_W-1:0] a_s;
  logic [B_W-1:0] do_s;

  arb_pick u_pick (
    .Req_P0     (Req_P0),
    .Req_P1     (Req_P1),
    .last_grant (last_r),
    .winner     (winner_s)
  );

  // Capture source: the fresh winner while idle, the current owner otherwise
  always_comb begin
    src_s  = Grant;
    req_s  = 1'b0;
    lock_s = 1'b0;
    wr_s   = 1'b0;
    a_s    = '0;
    do_s   = '0;
    if (state_r == ST_IDLE) begin
      src_s = winner_s;
    end else begin
      src_s = Grant;
    end
    if (src_s) begin
      req_s  = Req_P1;
      lock_s = Lock_P1;
      wr_s   = Wr_P1;
      a_s    = A_P1;
      do_s   = DO_P1;
    end else begin
      req_s  = Req_P0;
      lock_s = Lock_P0;
      wr_s   = Wr_P0;
      a_s    = A_P0;
      do_s   = DO_P0;
    end
  end

  // Transfer FSM; every memory-side and port-side output is a register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      last_r  <= '0;
      lock_r  <= 1'b0;
      Grant   <= 1'b0;
      Req_Low <= 1'b0;
      Wr_Low  <= 1'b0;
      A_Low   <= '0;
      DO_Low  <= '0;
      Rdy_P0  <= 1'b0;
      Rdy_P1  <= 1'b0;
      DI_P0   <= '0;
      DI_P1   <= '0;
    end else begin
      Rdy_P0 <= 1'b0;
      Rdy_P1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Req_P0 || Req_P1) begin
            state_r <= ST_BUSY;
            Grant   <= winner_s;
            last_r  <= winner_s;
            Req_Low <= 1'b1;
            Wr_Low  <= wr_s;
            A_Low   <= a_s;
            DO_Low  <= do_s;
          end
        end
        ST_BUSY: begin
          if (Rdy_Low) begin
            state_r <= ST_DONE;
            Req_Low <= 1'b0;
            Wr_Low  <= 1'b0;
            lock_r  <= lock_s;
            if (Grant) begin
              Rdy_P1 <= 1'b1;
              DI_P1  <= DI_Low;
            end else begin
              Rdy_P0 <= 1'b1;
              DI_P0  <= DI_Low;
            end
          end
        end
        ST_DONE: begin
          // Locked owner still requesting: chain its next transfer, pointer untouched
          if (lock_r && req_s) begin
            state_r <= ST_BUSY;
            Req_Low <= 1'b1;
            Wr_Low  <= wr_s;
            A_Low   <= a_s;
            DO_Low  <= do_s;
          end else begin
            state_r <= ST_IDLE;
          end
          lock_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          Req_Low <= 1'b0;
          Wr_Low  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int A_W = ARB_A_W;
    localparam int B_W = ARB_B_W;

    logic clk = 1'b0;
    logic rst;
    logic Req_P0, Req_P1, Wr_P0, Wr_P1, Lock_P0, Lock_P1;
    logic [A_W-1:0] A_P0, A_P1, A_Low;
    logic [B_W-1:0] DO_P0, DO_P1, DI_P0, DI_P1, DO_Low, DI_Low;
    logic Rdy_P0, Rdy_P1, Req_Low, Wr_Low, Rdy_Low, Grant;

    int total = 0;
    int passed = 0;

    // Reference model: last granted port, last refill data seen by each port, expected memory request
    logic last_m = 1'b0;
    logic [B_W-1:0] di_m [2];
    logic [A_W-1:0] exp_a_m;
    logic exp_wr_m;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .Req_P0(Req_P0), .Req_P1(Req_P1), .Wr_P0(Wr_P0), .Wr_P1(Wr_P1),
        .Lock_P0(Lock_P0), .Lock_P1(Lock_P1), .A_P0(A_P0), .A_P1(A_P1),
        .DO_P0(DO_P0), .DO_P1(DO_P1), .Rdy_P0(Rdy_P0), .Rdy_P1(Rdy_P1),
        .DI_P0(DI_P0), .DI_P1(DI_P1), .Req_Low(Req_Low), .Wr_Low(Wr_Low),
        .A_Low(A_Low), .DO_Low(DO_Low), .Rdy_Low(Rdy_Low), .DI_Low(DI_Low),
        .Grant(Grant)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    function automatic logic [B_W-1:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [A_W-1:0] rand_addr();
        return A_W'($urandom());
    endfunction

    // Expected winner from the arbitration rules
    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !last_m;
`else
            return 1'b1;
`endif
        end
        return r1;
    endfunction

    function automatic logic port_req(input logic p);
        return p ? Req_P1 : Req_P0;
    endfunction

    function automatic logic port_lock(input logic p);
        return p ? Lock_P1 : Lock_P0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_port(input logic p, input logic req, input logic wr, input logic lock,
                             input logic [A_W-1:0] a, input logic [B_W-1:0] d);
        if (p) begin
            Req_P1 = req; Wr_P1 = wr; Lock_P1 = lock; A_P1 = a; DO_P1 = d;
        end else begin
            Req_P0 = req; Wr_P0 = wr; Lock_P0 = lock; A_P0 = a; DO_P0 = d;
        end
    endtask

    task automatic drop_port(input logic p);
        if (p) begin Req_P1 = 1'b0; Lock_P1 = 1'b0; end
        else begin Req_P0 = 1'b0; Lock_P0 = 1'b0; end
    endtask

    // Cross the edge that starts a transfer for port w and check the memory-side request
    task automatic go_busy(input logic w);
        logic [B_W-1:0] d_e;
        exp_wr_m = w ? Wr_P1 : Wr_P0;
        exp_a_m  = w ? A_P1 : A_P0;
        d_e      = w ? DO_P1 : DO_P0;
        tick();
        Rdy_Low = 1'b0;
        @(negedge clk);
        total++; if (Req_Low === 1'b1) passed++; else $error("FAIL req_low_busy: observed %0h", Req_Low);
        total++; if (Grant === w) passed++; else $error("FAIL grant: observed %0h expected %0h", Grant, w);
        total++; if (Wr_Low === exp_wr_m) passed++; else $error("FAIL wr_low: observed %0h expected %0h", Wr_Low, exp_wr_m);
        total++; if (A_Low === exp_a_m) passed++; else $error("FAIL a_low: observed %0h expected %0h", A_Low, exp_a_m);
        total++; if (DO_Low === d_e) passed++; else $error("FAIL do_low: observed %0h expected %0h", DO_Low, d_e);
        total++; if (Rdy_P0 === 1'b0) passed++; else $error("FAIL rdy0_busy: observed %0h", Rdy_P0);
        total++; if (Rdy_P1 === 1'b0) passed++; else $error("FAIL rdy1_busy: observed %0h", Rdy_P1);
    endtask

    task automatic arb_launch(output logic w);
        w = pick(Req_P0, Req_P1);
        last_m = w;
        go_busy(w);
    endtask

    // Wait dly cycles in BUSY (scrambling the owner's inputs), then complete with data
    task automatic complete(input logic w, input int dly, input logic [B_W-1:0] data);
        for (int i = 0; i < dly; i++) begin
            if (w) A_P1 = rand_addr(); else A_P0 = rand_addr();
            tick();
            @(negedge clk);
            total++; if (Req_Low === 1'b1) passed++; else $error("FAIL req_hold: observed %0h", Req_Low);
            total++; if (A_Low === exp_a_m) passed++; else $error("FAIL a_hold: observed %0h expected %0h", A_Low, exp_a_m);
            total++; if (Wr_Low === exp_wr_m) passed++; else $error("FAIL wr_hold: observed %0h expected %0h", Wr_Low, exp_wr_m);
            total++; if ((Rdy_P0 | Rdy_P1) === 1'b0) passed++; else $error("FAIL rdy_early");
        end
        Rdy_Low = 1'b1;
        DI_Low  = data;
        tick();
        Rdy_Low = 1'b0;
        DI_Low  = ~data;
        di_m[w] = data;
        @(negedge clk);
        total++; if (Rdy_P0 === !w) passed++; else $error("FAIL rdy0_done: observed %0h", Rdy_P0);
        total++; if (Rdy_P1 === w) passed++; else $error("FAIL rdy1_done: observed %0h", Rdy_P1);
        total++; if (DI_P0 === di_m[0]) passed++; else $error("FAIL di0: observed %0h expected %0h", DI_P0, di_m[0]);
        total++; if (DI_P1 === di_m[1]) passed++; else $error("FAIL di1: observed %0h expected %0h", DI_P1, di_m[1]);
        total++; if (Req_Low === 1'b0) passed++; else $error("FAIL req_low_done: observed %0h", Req_Low);
    endtask

    task automatic release_port(input logic w);
        drop_port(w);
        tick();
        @(negedge clk);
        total++; if (Req_Low === 1'b0) passed++; else $error("FAIL req_low_idle: observed %0h", Req_Low);
        total++; if ((Rdy_P0 | Rdy_P1) === 1'b0) passed++; else $error("FAIL rdy_idle");
    endtask

    task automatic serve(input int dly);
        logic w;
        arb_launch(w);
        complete(w, dly, rand_blk());
        release_port(w);
    endtask

    // Main stimulus sequence
    initial begin
        logic w;
        logic [2:0] tie_exp;
        rst = 1'b0;
        Rdy_Low = 1'b0;
        DI_Low = '0;
        load_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        load_port(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        di_m[0] = '0;
        di_m[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (Req_Low === 1'b0) passed++; else $error("FAIL rst_req_low: observed %0h", Req_Low);
        total++; if (Wr_Low === 1'b0) passed++; else $error("FAIL rst_wr_low: observed %0h", Wr_Low);
        total++; if (A_Low === '0) passed++; else $error("FAIL rst_a_low: observed %0h", A_Low);
        total++; if (DO_Low === '0) passed++; else $error("FAIL rst_do_low: observed %0h", DO_Low);
        total++; if ((Rdy_P0 | Rdy_P1) === 1'b0) passed++; else $error("FAIL rst_rdy");
        total++; if ((DI_P0 | DI_P1) === '0) passed++; else $error("FAIL rst_di");
        total++; if (Grant === 1'b0) passed++; else $error("FAIL rst_grant: observed %0h", Grant);
        rst = 1'b1;

        // Single refill on port 0
        load_port(1'b0, 1'b1, 1'b0, 1'b0, 28'h0000123, rand_blk());
        arb_launch(w);
        total++; if (A_Low === 28'h0000123) passed++; else $error("FAIL single_addr: observed %0h", A_Low);
        complete(w, 3, {16{8'hA5}});
        total++; if (DI_P0 === {16{8'hA5}}) passed++; else $error("FAIL single_di: observed %0h", DI_P0);
        release_port(w);

        // Three ties in a row
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp = 3'b101;
`else
        tie_exp = 3'b111;
`endif
        for (int r = 0; r < 3; r++) begin
            load_port(1'b0, 1'b1, 1'b0, 1'b0, rand_addr(), rand_blk());
            load_port(1'b1, 1'b1, 1'b0, 1'b0, rand_addr(), rand_blk());
            arb_launch(w);
            total++; if (Grant === tie_exp[r]) passed++; else $error("FAIL tie_grant: observed %0h expected %0h", Grant, tie_exp[r]);
            complete(w, r, rand_blk());
            release_port(w);
        end
        serve(1);

        // Locked write-back then refill on port 1 while port 0 waits
        load_port(1'b1, 1'b1, 1'b1, 1'b1, 28'h0ABCDEF, rand_blk());
        load_port(1'b0, 1'b1, 1'b0, 1'b0, rand_addr(), rand_blk());
        arb_launch(w);
        total++; if (Grant === 1'b1) passed++; else $error("FAIL lock_wb_grant: observed %0h", Grant);
        total++; if (Wr_Low === 1'b1) passed++; else $error("FAIL lock_wb_wr: observed %0h", Wr_Low);
        complete(w, 1, rand_blk());
        load_port(1'b1, 1'b1, 1'b0, 1'b0, 28'h0ABCDEF, rand_blk());
        go_busy(1'b1);
        total++; if (A_Low === 28'h0ABCDEF) passed++; else $error("FAIL lock_refill_addr: observed %0h", A_Low);
        total++; if (Wr_Low === 1'b0) passed++; else $error("FAIL lock_refill_wr: observed %0h", Wr_Low);
        complete(1'b1, 2, rand_blk());
        release_port(1'b1);
        arb_launch(w);
        total++; if (Grant === 1'b0) passed++; else $error("FAIL lock_then_p0: observed %0h", Grant);
        complete(w, 0, rand_blk());
        release_port(w);

        // Reset two cycles into BUSY
        load_port(1'b0, 1'b1, 1'b0, 1'b0, rand_addr(), rand_blk());
        arb_launch(w);
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (Req_Low === 1'b0) passed++; else $error("FAIL rstbusy_req_low: observed %0h", Req_Low);
        total++; if ((DI_P0 | DI_P1) === '0) passed++; else $error("FAIL rstbusy_di");
        drop_port(1'b0);
        Rdy_Low = 1'b1;
        DI_Low = rand_blk();
        tick();
        @(negedge clk);
        total++; if ((Rdy_P0 | Rdy_P1) === 1'b0) passed++; else $error("FAIL rstbusy_no_rdy");
        rst = 1'b1;
        Rdy_Low = 1'b0;
        di_m[0] = '0;
        di_m[1] = '0;
        last_m = 1'b0;
        load_port(1'b1, 1'b1, 1'b0, 1'b0, rand_addr(), rand_blk());
        serve(2);

        // Stray memory ready while idle, then a requester dropping mid-transfer
        Rdy_Low = 1'b1;
        DI_Low = rand_blk();
        tick();
        tick();
        @(negedge clk);
        total++; if ((Rdy_P0 | Rdy_P1) === 1'b0) passed++; else $error("FAIL stray_rdy");
        total++; if (Req_Low === 1'b0) passed++; else $error("FAIL stray_req_low: observed %0h", Req_Low);
        total++; if (DI_P1 === di_m[1]) passed++; else $error("FAIL stray_di1: observed %0h expected %0h", DI_P1, di_m[1]);
        Rdy_Low = 1'b0;
        load_port(1'b0, 1'b1, 1'b0, 1'b0, rand_addr(), rand_blk());
        arb_launch(w);
        drop_port(w);
        complete(w, 2, rand_blk());
        release_port(w);

        // Randomized traffic with ties, locks, drops and stray ready pulses
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1 || (p == 1 && !Req_P0))
                    load_port(1'(p), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              rand_addr(), rand_blk());
            end
            while (Req_P0 || Req_P1) begin
                Rdy_Low = 1'($urandom_range(0, 1));
                DI_Low = rand_blk();
                arb_launch(w);
                for (int j = 0; j < 4; j++) begin
                    if ($urandom_range(0, 3) == 0) drop_port(w);
                    complete(w, $urandom_range(0, 3), rand_blk());
                    if (port_req(w) && port_lock(w) && j < 3 && $urandom_range(0, 1) == 1) begin
                        load_port(w, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  rand_addr(), rand_blk());
                        go_busy(w);
                    end else begin
                        release_port(w);
                        break;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL expose parameters, one per line: N_PORTS, 2, number of cache requesters (fixed; port 0 = I-cache, port 1 = D-cache); A_W, `Width_of_A_Low (28), block address width; B_W, `Memory_Block_Size (128), block data width.
REQ-002 SHALL expose these ports, one per line; one clock; reset is asynchronous and active-low:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
Req_P0 / Req_P1  in  1  block request from port n, level, held until Rdy_Pn
Wr_P0 / Wr_P1  in  1  1 = write-back block, 0 = refill read
Lock_P0 / Lock_P1  in  1  keep the grant on port n for its next request (write-back then refill)
A_P0 / A_P1  in  A_W  block address from port n
DO_P0 / DO_P1  in  B_W  write-back data from port n
Rdy_P0 / Rdy_P1  out  1  one-cycle completion pulse to port n
DI_P0 / DI_P1  out  B_W  refill data to port n, valid while Rdy_Pn=1
Req_Low  out  1  request to memory
Wr_Low  out  1  memory write strobe
A_Low  out  A_W  memory block address
DO_Low  out  B_W  memory write data
Rdy_Low  in  1  memory completion, one or more cycles high
DI_Low  in  B_W  memory read data, valid with Rdy_Low
Grant  out  1  index of the owning port, informational

Function
REQ-003 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE. The only other transition is DONE -> BUSY when the lock holds.
REQ-004 In IDLE with any Req_Pn=1 at edge k: SHALL pick the winner, register Wr/A/DO of the winner, enter BUSY. Req_Low=1 from cycle k+1.
REQ-005 In BUSY: Req_Low=1 and Wr_Low/A_Low/DO_Low SHALL come from the registered copies only. They stay stable until Rdy_Low is sampled.
REQ-006 Rdy_Low=1 sampled at edge m in BUSY: SHALL register DI_Low into DI_Pn of the owner and enter DONE. Rdy_Pn=1 for exactly cycle m+1. Req_Low=0 in cycle m+1.
REQ-007 In DONE: SHALL ignore Req_Pn for arbitration, because requesters drop Req in this cycle. The next grant is decided in IDLE or in the lock path.
REQ-008 Lock: if Lock_Pn of the owner was 1 at the BUSY->DONE edge and Req_Pn=1 at the DONE edge, SHALL enter BUSY for the same port without arbitration.
REQ-009 The non-owning port SHALL never see Rdy_Pn=1. Its DI_Pn SHALL hold its last value.
REQ-010 Req_Pn dropping during BUSY SHALL NOT abort the transfer. Completion still pulses Rdy_Pn.
REQ-011 Rdy_Low=1 in IDLE or DONE SHALL be ignored.
REQ-012 No timeout: BUSY SHALL wait indefinitely for Rdy_Low.

Reset
REQ-013 rst=0 SHALL asynchronously force: state=IDLE; Req_Low, Wr_Low, Rdy_P0, Rdy_P1 = 0; A_Low, DO_Low, DI_P0, DI_P1 = 0; Grant=0; round-robin pointer=0.
REQ-014 Reset during BUSY SHALL drop Req_Low in the same cycle, with no Rdy_Pn pulse. After release, the first request is arbitrated afresh.

Configuration
REQ-015 Macro ARB_ROUND_ROBIN_EN. Defined: on simultaneous requests, the winner is the port not granted last. The pointer updates on every IDLE->BUSY grant and does not update on lock re-grants. Undefined: fixed priority, port 1 (D-cache) always wins ties.

Structure
REQ-016 A shared package SHALL hold the A_W/B_W constants (same values as `Width_of_A_Low/`Memory_Block_Size) and the FSM state encoding (2-bit: IDLE=0, BUSY=1, DONE=2).
REQ-017 Winner selection SHALL be a sub-module arb_pick, inputs Req_P0, Req_P1, last-grant pointer, output winner. Its round-robin/fixed-priority behaviour follows REQ-015.

Verification
REQ-018 Single read: Req_P0=1, Wr=0, A_P0=0x0000123. Rdy_Low after 3 cycles with DI_Low=0xA5..A5 -> A_Low=0x0000123, Wr_Low=0, Rdy_P0 pulses 1 cycle, DI_P0=0xA5..A5, Rdy_P1 stays 0.
REQ-019 Tie: Req_P0=Req_P1=1 in IDLE, three times in a row. With ARB_ROUND_ROBIN_EN -> grants 1,0,1. Without it -> grants 1,1,1.
REQ-020 Locked dirty miss: port 1 issues Wr=1 A=0x0ABCDEF with Lock_P1=1, while Req_P0=1 is pending -> write completes, then read A=0x0ABCDEF follows with no port 0 grant in between, then port 0 is served.
REQ-021 Reset mid-BUSY: assert rst=0 two cycles into BUSY -> Req_Low=0 immediately, no Rdy pulse. After release, a new request completes normally.
REQ-022 Stray Rdy_Low=1 in IDLE -> no Rdy_Pn pulse, state stays IDLE. Req_P0 dropped mid-BUSY -> Rdy_P0 still pulses on Rdy_Low.
